// File: rtl/tlul_host_port.sv
// Single-beat TileLink-UL initiator. It turns a command/response interface
// into A-channel Get/PutFullData/PutPartialData requests and collects the
// D-channel acknowledgements. Source IDs come from a free pool, so up to
// 2^TL_RS requests can be outstanding and they may complete out of order.
module tlul_host_port #(
  parameter int TL_RS = 4,
  parameter int AW    = 32
) (
  input  logic              host_clock_i,
  input  logic              host_reset_i,
  // command side
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [AW-1:0]     cmd_address_i,
  input  logic [3:0]        cmd_mask_i,
  input  logic [31:0]       cmd_data_i,
  output logic [TL_RS-1:0]  cmd_source_o,
  // A channel
  output logic [2:0]        host_a_opcode,
  output logic [2:0]        host_a_param,
  output logic [3:0]        host_a_size,
  output logic [TL_RS-1:0]  host_a_source,
  output logic [AW-1:0]     host_a_address,
  output logic [3:0]        host_a_mask,
  output logic [31:0]       host_a_data,
  output logic              host_a_corrupt,
  output logic              host_a_valid,
  input  logic              host_a_ready,
  // D channel
  input  logic [2:0]        host_d_opcode,
  input  logic [1:0]        host_d_param,
  input  logic [3:0]        host_d_size,
  input  logic [TL_RS-1:0]  host_d_source,
  input  logic              host_d_denied,
  input  logic [31:0]       host_d_data,
  input  logic              host_d_corrupt,
  input  logic              host_d_valid,
  output logic              host_d_ready,
  // response side
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [TL_RS-1:0]  rsp_source_o,
  output logic              rsp_write_o,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_error_o,
  // status
  output logic              busy_o,
  output logic              unexpected_o
);

  localparam int NSRC = 1 << TL_RS;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  logic [NSRC-1:0]  busy_q, busy_d;
  logic [NSRC-1:0]  wr_q, wr_d;
  logic             a_valid_q, a_valid_d;
  logic [2:0]       a_opcode_q, a_opcode_d;
  logic [TL_RS-1:0] a_source_q, a_source_d;
  logic [AW-1:0]    a_address_q, a_address_d;
  logic [3:0]       a_mask_q, a_mask_d;
  logic [31:0]      a_data_q, a_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [TL_RS-1:0] rsp_source_q, rsp_source_d;
  logic             rsp_write_q, rsp_write_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_error_q, rsp_error_d;
  logic             unexpected_q, unexpected_d;

  logic             free_found;
  logic [TL_RS-1:0] alloc_idx;
  logic             cmd_fire, a_fire, d_fire, d_hit;

  // D opcode/param/size and the low address bits are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{host_d_opcode, host_d_param, host_d_size, cmd_address_i[1:0]};

  // Lowest-index free source: scan downward so the last hit is the lowest.
  always_comb begin
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        alloc_idx  = TL_RS'(i);
      end
    end
  end

  assign cmd_ready_o  = free_found & (~a_valid_q | host_a_ready);
  assign cmd_source_o = alloc_idx;
  assign cmd_fire     = cmd_valid_i & cmd_ready_o;
  assign a_fire       = a_valid_q & host_a_ready;
  assign host_d_ready = ~rsp_valid_q | rsp_ready_i;
  assign d_fire       = host_d_valid & host_d_ready;
  assign d_hit        = busy_q[host_d_source];

  // Next-state for source pool, A request register and response register.
  always_comb begin
    busy_d       = busy_q;
    wr_d         = wr_q;
    a_valid_d    = a_valid_q;
    a_opcode_d   = a_opcode_q;
    a_source_d   = a_source_q;
    a_address_d  = a_address_q;
    a_mask_d     = a_mask_q;
    a_data_d     = a_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_source_d = rsp_source_q;
    rsp_write_d  = rsp_write_q;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;
    unexpected_d = unexpected_q;

    // Free first: an allocated ID is never the one being freed this cycle.
    if (d_fire && d_hit) begin
      busy_d[host_d_source] = 1'b0;
    end
    if (cmd_fire) begin
      busy_d[alloc_idx] = 1'b1;
      wr_d[alloc_idx]   = cmd_write_i;
    end

    if (cmd_fire) begin
      a_valid_d   = 1'b1;
      a_source_d  = alloc_idx;
      a_address_d = {cmd_address_i[AW-1:2], 2'b00};
      a_data_d    = cmd_data_i;
      if (!cmd_write_i) begin
        a_opcode_d = OP_GET;
        a_mask_d   = 4'hF;
      end else begin
        a_opcode_d = (cmd_mask_i == 4'hF) ? OP_PUT_FULL : OP_PUT_PART;
        a_mask_d   = cmd_mask_i;
      end
    end else if (a_fire) begin
      a_valid_d = 1'b0;
    end

    if (d_fire && d_hit) begin
      rsp_valid_d  = 1'b1;
      rsp_source_d = host_d_source;
      rsp_write_d  = wr_q[host_d_source];
      rsp_data_d   = wr_q[host_d_source] ? 32'h0 : host_d_data;
      rsp_error_d  = host_d_denied | host_d_corrupt;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    if (d_fire && !d_hit) begin
      unexpected_d = 1'b1;
    end
  end

  // State registers; reset clears every outstanding request and payload.
  always_ff @(posedge host_clock_i or posedge host_reset_i) begin
    if (host_reset_i) begin
      busy_q       <= '0;
      wr_q         <= '0;
      a_valid_q    <= 1'b0;
      a_opcode_q   <= '0;
      a_source_q   <= '0;
      a_address_q  <= '0;
      a_mask_q     <= '0;
      a_data_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_source_q <= '0;
      rsp_write_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      unexpected_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      wr_q         <= wr_d;
      a_valid_q    <= a_valid_d;
      a_opcode_q   <= a_opcode_d;
      a_source_q   <= a_source_d;
      a_address_q  <= a_address_d;
      a_mask_q     <= a_mask_d;
      a_data_q     <= a_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_source_q <= rsp_source_d;
      rsp_write_q  <= rsp_write_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
      unexpected_q <= unexpected_d;
    end
  end

  assign host_a_valid   = a_valid_q;
  assign host_a_opcode  = a_opcode_q;
  assign host_a_param   = 3'd0;
  assign host_a_size    = 4'd2;
  assign host_a_source  = a_source_q;
  assign host_a_address = a_address_q;
  assign host_a_mask    = a_mask_q;
  assign host_a_data    = a_data_q;
  assign host_a_corrupt = 1'b0;

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_source_o = rsp_source_q;
  assign rsp_write_o  = rsp_write_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_error_o  = rsp_error_q;

  assign busy_o       = |busy_q;
  assign unexpected_o = unexpected_q;

endmodule

// File: tb/tb_tlul_host_port.sv
// Directed testbench for tlul_host_port with hand-computed expectations.
module tb_tlul_host_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic [31:0] cmd_address_i = '0;
  logic [3:0]  cmd_mask_i = '0;
  logic [31:0] cmd_data_i = '0;
  logic [3:0]  cmd_source_o;
  logic [2:0]  host_a_opcode;
  logic [2:0]  host_a_param;
  logic [3:0]  host_a_size;
  logic [3:0]  host_a_source;
  logic [31:0] host_a_address;
  logic [3:0]  host_a_mask;
  logic [31:0] host_a_data;
  logic        host_a_corrupt;
  logic        host_a_valid;
  logic        host_a_ready = 1'b1;
  logic [2:0]  host_d_opcode = 3'd1;
  logic [1:0]  host_d_param = '0;
  logic [3:0]  host_d_size = 4'd2;
  logic [3:0]  host_d_source = '0;
  logic        host_d_denied = 1'b0;
  logic [31:0] host_d_data = '0;
  logic        host_d_corrupt = 1'b0;
  logic        host_d_valid = 1'b0;
  logic        host_d_ready;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [3:0]  rsp_source_o;
  logic        rsp_write_o;
  logic [31:0] rsp_data_o;
  logic        rsp_error_o;
  logic        busy_o;
  logic        unexpected_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tlul_host_port #(.TL_RS(4), .AW(32)) dut (
    .host_clock_i(clk), .host_reset_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_address_i(cmd_address_i), .cmd_mask_i(cmd_mask_i), .cmd_data_i(cmd_data_i),
    .cmd_source_o(cmd_source_o),
    .host_a_opcode(host_a_opcode), .host_a_param(host_a_param), .host_a_size(host_a_size),
    .host_a_source(host_a_source), .host_a_address(host_a_address), .host_a_mask(host_a_mask),
    .host_a_data(host_a_data), .host_a_corrupt(host_a_corrupt),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready),
    .host_d_opcode(host_d_opcode), .host_d_param(host_d_param), .host_d_size(host_d_size),
    .host_d_source(host_d_source), .host_d_denied(host_d_denied), .host_d_data(host_d_data),
    .host_d_corrupt(host_d_corrupt), .host_d_valid(host_d_valid), .host_d_ready(host_d_ready),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_source_o(rsp_source_o),
    .rsp_write_o(rsp_write_o), .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
    .busy_o(busy_o), .unexpected_o(unexpected_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one command for one edge; checks readiness and the assigned source.
  task automatic issue(input logic w, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic [3:0] exp_src);
    cmd_valid_i   = 1'b1;
    cmd_write_i   = w;
    cmd_address_i = addr;
    cmd_mask_i    = mask;
    cmd_data_i    = data;
    #1;
    chk("cmd_ready", cmd_ready_o, 1'b1);
    chk("cmd_source", cmd_source_o, exp_src);
    step();
    cmd_valid_i = 1'b0;
  endtask

  // Drive one D beat for one edge.
  task automatic d_beat(input logic [3:0] src, input logic [31:0] data,
                        input logic denied, input logic corrupt);
    host_d_valid   = 1'b1;
    host_d_source  = src;
    host_d_data    = data;
    host_d_denied  = denied;
    host_d_corrupt = corrupt;
    step();
    host_d_valid   = 1'b0;
    host_d_denied  = 1'b0;
    host_d_corrupt = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic [3:0] src, input logic w,
                         input logic [31:0] data, input logic err);
    chk({tag, "_valid"}, rsp_valid_o, 1'b1);
    chk({tag, "_source"}, rsp_source_o, src);
    chk({tag, "_write"}, rsp_write_o, w);
    chk({tag, "_data"}, rsp_data_o, data);
    chk({tag, "_error"}, rsp_error_o, err);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_a_valid", host_a_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_unexpected", unexpected_o, 1'b0);
    chk("rst_a_data", host_a_data, 32'h0);
    chk("rst_a_addr", host_a_address, 32'h0);
    chk("rst_rsp_data", rsp_data_o, 32'h0);
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_cmd_source", cmd_source_o, 4'd0);
    step();
    step();
    rst = 1'b0;

    // single Get; low address bits dropped, mask forced F
    issue(1'b0, 32'h0000_0007, 4'h3, 32'h0, 4'd0);
    chk("get_a_valid", host_a_valid, 1'b1);
    chk("get_opcode", host_a_opcode, 3'd4);
    chk("get_size", host_a_size, 4'd2);
    chk("get_param", host_a_param, 3'd0);
    chk("get_corrupt", host_a_corrupt, 1'b0);
    chk("get_mask", host_a_mask, 4'hF);
    chk("get_source", host_a_source, 4'd0);
    chk("get_addr", host_a_address, 32'h0000_0004);
    chk("get_busy", busy_o, 1'b1);
    d_beat(4'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk_rsp("get_rsp", 4'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    chk("get_busy_after", busy_o, 1'b0);
    chk("get_a_drained", host_a_valid, 1'b0);
    step();
    chk("get_rsp_popped", rsp_valid_o, 1'b0);

    // Puts back to back: full mask then partial mask
    issue(1'b1, 32'h0000_0100, 4'hF, 32'h1111_1111, 4'd0);
    chk("putf_opcode", host_a_opcode, 3'd0);
    chk("putf_source", host_a_source, 4'd0);
    chk("putf_data", host_a_data, 32'h1111_1111);
    issue(1'b1, 32'h0000_0104, 4'h3, 32'h2222_2222, 4'd1);
    chk("putp_opcode", host_a_opcode, 3'd1);
    chk("putp_source", host_a_source, 4'd1);
    chk("putp_mask", host_a_mask, 4'h3);
    chk("putp_addr", host_a_address, 32'h0000_0104);
    d_beat(4'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk_rsp("putp_rsp", 4'd1, 1'b1, 32'h0, 1'b0);
    d_beat(4'd0, 32'hAAAA_AAAA, 1'b0, 1'b0);
    chk_rsp("putf_rsp", 4'd0, 1'b1, 32'h0, 1'b0);
    chk("put_busy_after", busy_o, 1'b0);
    step();

    // exhaust the pool
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 32'(i * 4), 4'hF, 32'h0, 4'(i));
    end
    chk("full_busy", busy_o, 1'b1);
    chk("full_cmd_ready", cmd_ready_o, 1'b0);
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    chk("full_cmd_ready2", cmd_ready_o, 1'b0);
    chk("full_a_valid", host_a_valid, 1'b0);
    d_beat(4'd5, 32'h0000_0055, 1'b0, 1'b0);
    chk_rsp("full_rsp5", 4'd5, 1'b0, 32'h0000_0055, 1'b0);
    chk("refill_ready", cmd_ready_o, 1'b1);
    issue(1'b0, 32'h0000_0500, 4'hF, 32'h0, 4'd5);
    chk("refill_a_source", host_a_source, 4'd5);

    // reset mid-transfer, then a late beat is unexpected
    do_reset();
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_a_valid", host_a_valid, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
    d_beat(4'd3, 32'h3333_3333, 1'b0, 1'b0);
    chk("late_rsp_valid", rsp_valid_o, 1'b0);
    chk("late_unexpected", unexpected_o, 1'b1);
    do_reset();
    chk("late_unexp_cleared", unexpected_o, 1'b0);

    // A-channel backpressure holds payload
    host_a_ready = 1'b0;
    issue(1'b1, 32'h0000_0200, 4'hC, 32'hCAFE_F00D, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_cmd_ready", cmd_ready_o, 1'b0);
      chk("stall_a_valid", host_a_valid, 1'b1);
      chk("stall_opcode", host_a_opcode, 3'd1);
      chk("stall_addr", host_a_address, 32'h0000_0200);
      chk("stall_mask", host_a_mask, 4'hC);
      chk("stall_data", host_a_data, 32'hCAFE_F00D);
      step();
    end
    host_a_ready = 1'b1;
    step();
    chk("stall_a_drained", host_a_valid, 1'b0);

    // response backpressure; denied reports error
    rsp_ready_i = 1'b0;
    d_beat(4'd0, 32'h1234_5678, 1'b1, 1'b0);
    chk_rsp("denied_rsp", 4'd0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h0000_0300, 4'hF, 32'h0, 4'd0);
    host_d_valid  = 1'b1;
    host_d_source = 4'd0;
    host_d_data   = 32'h0000_1234;
    #1;
    chk("bp_d_ready", host_d_ready, 1'b0);
    step();
    chk_rsp("bp_rsp_hold", 4'd0, 1'b1, 32'h0, 1'b1);
    chk("bp_busy_hold", busy_o, 1'b1);
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_d_ready_rel", host_d_ready, 1'b1);
    step();
    host_d_valid = 1'b0;
    chk_rsp("bp_rsp_new", 4'd0, 1'b0, 32'h0000_1234, 1'b0);
    step();
    chk("bp_rsp_popped", rsp_valid_o, 1'b0);

    // stray beat with nothing outstanding
    d_beat(4'd9, 32'h9999_9999, 1'b0, 1'b0);
    chk("stray_rsp_valid", rsp_valid_o, 1'b0);
    chk("stray_unexpected", unexpected_o, 1'b1);
    step();
    step();
    chk("stray_sticky", unexpected_o, 1'b1);
    do_reset();
    chk("stray_cleared", unexpected_o, 1'b0);

    // out-of-order completion
    issue(1'b0, 32'h0000_0010, 4'hF, 32'h0, 4'd0);
    issue(1'b1, 32'h0000_0014, 4'hF, 32'h5555_5555, 4'd1);
    issue(1'b0, 32'h0000_0018, 4'hF, 32'h0, 4'd2);
    d_beat(4'd2, 32'h0000_0022, 1'b0, 1'b0);
    chk_rsp("ooo_rsp2", 4'd2, 1'b0, 32'h0000_0022, 1'b0);
    d_beat(4'd0, 32'h0000_00A0, 1'b0, 1'b1);
    chk_rsp("ooo_rsp0", 4'd0, 1'b0, 32'h0000_00A0, 1'b1);
    d_beat(4'd1, 32'h0000_0099, 1'b0, 1'b0);
    chk_rsp("ooo_rsp1", 4'd1, 1'b1, 32'h0, 1'b0);
    chk("ooo_busy", busy_o, 1'b0);
    chk("ooo_unexpected", unexpected_o, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlul_host_port.md
# tlul_host_port

Single-beat TileLink-UL initiator that turns a simple command/response interface into A-channel Get/PutFullData/PutPartialData requests and collects D-channel acknowledgements. It sits between a bus-mastering block (DMA engine, debug bridge, test sequencer) and the crossbar that fronts TL-UL responders such as the GPIO and timer slaves. It allocates source IDs from a free pool, tracks up to 2^TL_RS outstanding requests, and returns responses tagged with their source.

## Interface
- TL_RS, 4: source ID width; maximum outstanding requests = 2^TL_RS.
- AW, 32: address width.

- host_clock_i  in  1  clock; all logic on rising edge.
- host_reset_i  in  1  asynchronous, active-high reset.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
- cmd_write_i  in  1  1 = Put, 0 = Get.
- cmd_address_i  in  AW  byte address; bits [1:0] ignored.
- cmd_mask_i  in  4  byte enables for Put; ignored for Get.
- cmd_data_i  in  32  write data.
- host_a_opcode / host_a_param / host_a_size / host_a_source / host_a_address / host_a_mask / host_a_data / host_a_corrupt  out  3/3/4/TL_RS/AW/4/32/1  A-channel payload.
- host_a_valid  out  1 / host_a_ready  in  1.
- host_d_opcode / host_d_param / host_d_size / host_d_source / host_d_denied / host_d_data / host_d_corrupt  in  3/2/4/TL_RS/1/32/1  D-channel payload.
- host_d_valid  in  1 / host_d_ready  out  1.
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
- rsp_source_o  out  TL_RS  source ID of the completed request.
- rsp_write_o  out  1  completed request was a Put.
- rsp_data_o  out  32  read data (valid for Get only; 0 for Put).
- rsp_error_o  out  1  host_d_denied | host_d_corrupt.
- cmd_source_o  out  TL_RS  source ID assigned to the command being accepted this cycle.
- busy_o  out  1  at least one request outstanding.
- unexpected_o  out  1  sticky: D beat received for a source not outstanding.

## Operation
- Free pool: bitmap of 2^TL_RS entries plus per-source write flag. Allocation picks lowest-index free source; cmd_source_o shows it combinationally.
- cmd_ready_o = free source exists AND (A register empty OR host_a_ready).
- On command accept: A register loads; source marked busy; write flag recorded.
- A payload: opcode 4 (Get) if !cmd_write_i; 0 (PutFullData) if write and mask==4'hF; 1 (PutPartialData) otherwise. param 0, size 2, corrupt 0, address with [1:0]=0, mask forced 4'hF for Get, data as given.
- A register holds payload stable while host_a_valid & !host_a_ready.
- D side: one response register. host_d_ready = !rsp_valid_o | rsp_ready_i.
- On D accept with source busy: response register loads source, stored write flag, data (0 if write), error; source freed.
- On D accept with source not busy: beat consumed and discarded, no response, unexpected_o set until reset.
- host_d_opcode, param, size are not checked.
- busy_o = any bitmap bit set.

## Timing
- Reset (async assert, sync-release usage): host_a_valid 0, rsp_valid_o 0, bitmap all free, unexpected_o 0, A/rsp payload registers 0.
- Command accepted in cycle N -> host_a_valid high cycle N+1.
- Back-to-back commands at full rate when host_a_ready held high and sources available.
- D accepted in cycle N -> rsp_valid_o high cycle N+1; back-to-back at full rate when rsp_ready_i held high.
- Freed source allocatable from cycle N+1 (registered bitmap); alloc and free of different IDs in same cycle both take effect.
- Pool full: cmd_ready_o 0 until a D beat is accepted.
- Responses may complete out of order; rsp_source_o identifies each.
- Reset mid-transfer discards all outstanding state; late D beats afterward set unexpected_o.

## Test plan
- Reset, then Get to 0x4 with slave returning data 0xDEADBEEF source 0 -> A: opcode 4, size 2, mask F, source 0; rsp: source 0, write 0, data 0xDEADBEEF, error 0; busy_o back to 0.
- Puts with mask F and mask 3 -> opcodes 0 and 1, sources 0 and 1, rsp_write_o 1, rsp_data_o 0.
- Issue 16 Gets with TL_RS=4, no D returns -> sources 0..15, cmd_ready_o low on 17th; return source 5 -> next command gets source 5 one cycle later.
- host_a_ready held low 3 cycles -> A payload stable, cmd_ready_o low; rsp_ready_i low with D pending -> host_d_ready low, rsp register unchanged.
- D beat source 9 with nothing outstanding -> no rsp_valid_o, unexpected_o 1 until reset; D with denied=1 -> rsp_error_o 1.
- Out-of-order: sources 0,1,2 outstanding, return 2,0,1 -> rsp_source_o 2,0,1 with matching write flags.
